// File: rtl/banco_registrador_param_pkg.sv
// Shared definitions for the parametrised register bank: default geometry
// and the clear-sweep FSM state encoding.
package banco_registrador_param_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/banco_registrador_param_clear_fsm.sv
// Clear-sweep controller: walks clr_idx from 0 to DEPTH-1, one register per
// clock, while busy is high. A clear request is only sampled in IDLE.
module rb_clear_fsm
    import banco_registrador_param_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_idx_o
);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value, independent of block order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // The counter wraps to 0 on the same edge that leaves CLEAR.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o    = (state_q == ST_CLEAR);
    assign clr_en_o  = (state_q == ST_CLEAR);
    assign clr_idx_o = cnt_q;

endmodule

// File: rtl/banco_registrador_param.sv
// DEPTH x WIDTH register file: two combinational read ports, one write port,
// per-register valid bits, optional write-through bypass and hardwired r0.
module banco_registrador_param
    import banco_registrador_param_pkg::*;
#(
    parameter  int unsigned WIDTH    = DEF_WIDTH,
    parameter  int unsigned DEPTH    = DEF_DEPTH,
    parameter  bit          BYPASS   = 1'b1,
    parameter  bit          ZERO_REG = 1'b0,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] dr,
    input  logic [WIDTH-1:0]  wrData,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    output logic [WIDTH-1:0]  rdData1,
    output logic [WIDTH-1:0]  rdData2,
    output logic              rdValid1,
    output logic              rdValid2,
    input  logic              clear,
    output logic              busy,
    output logic              wr_drop
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } rd_t;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic              wr_drop_q, wr_drop_d;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_accept;
    rd_t               rd1, rd2;

    rb_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (reset),
        .clear_i   (clear),
        .busy_o    (busy),
        .clr_en_o  (clr_en),
        .clr_idx_o (clr_idx)
    );

    // Writes are refused while sweeping and, with a hardwired r0, to r0.
    assign wr_accept = write && !clr_en && !(ZERO_REG && (dr == '0));
    assign wr_drop_d = write && !wr_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is reset explicitly because every register and
            // valid bit must read 0 straight after reset; this keeps it in flops.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q   <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
            if (clr_en) begin
                mem_q[clr_idx]   <= '0;
                valid_q[clr_idx] <= 1'b0;
            end else if (wr_accept) begin
                mem_q[dr]   <= wrData;
                valid_q[dr] <= 1'b1;
            end
        end
    end

    function automatic rd_t read_port(input logic [ADDR_W-1:0] addr);
        rd_t r;
        if (ZERO_REG && (addr == '0)) begin
            r.valid = 1'b1;
            r.data  = '0;
        end else if (BYPASS && wr_accept && (addr == dr)) begin
            r.valid = 1'b1;
            r.data  = wrData;
        end else begin
            r.valid = valid_q[addr];
            r.data  = mem_q[addr];
        end
        return r;
    endfunction

    always_comb begin
        rd1 = read_port(sr1);
        rd2 = read_port(sr2);
    end

    assign rdData1  = rd1.data;
    assign rdValid1 = rd1.valid;
    assign rdData2  = rd2.data;
    assign rdValid2 = rd2.valid;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_banco_registrador_param.sv
// Self-checking bench: three bank configurations driven in parallel and
// compared every cycle against an array-based reference model.
module tb_banco_registrador_param;
    import banco_registrador_param_pkg::*;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int NC = 3;   // 0: BYPASS=1, 1: BYPASS=0, 2: BYPASS=1 + ZERO_REG=1

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] dr = '0, sr1 = '0, sr2 = '0;
    logic [7:0] wrData = '0;

    logic [7:0] rd1 [NC];
    logic [7:0] rd2 [NC];
    logic       v1 [NC], v2 [NC], busy [NC], drop [NC];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        banco_registrador_param #(
            .WIDTH    (W),
            .DEPTH    (D),
            .BYPASS   (g != 1),
            .ZERO_REG (g == 2)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .write    (write),
            .dr       (dr),
            .wrData   (wrData),
            .sr1      (sr1),
            .sr2      (sr2),
            .rdData1  (rd1[g]),
            .rdData2  (rd2[g]),
            .rdValid1 (v1[g]),
            .rdValid2 (v2[g]),
            .clear    (clear),
            .busy     (busy[g]),
            .wr_drop  (drop[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model
    bit cfg_byp [NC] = '{1'b1, 1'b0, 1'b1};
    bit cfg_zr  [NC] = '{1'b0, 1'b0, 1'b1};
    int m_mem  [NC][D];
    bit m_val  [NC][D];
    bit m_drop [NC];
    bit m_sweep;
    int m_idx;

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) begin
            for (int a = 0; a < D; a++) begin
                m_mem[c][a] = 0;
                m_val[c][a] = 1'b0;
            end
            m_drop[c] = 1'b0;
        end
        m_sweep = 1'b0;
        m_idx   = 0;
    endfunction

    function automatic bit accepted(input int c);
        return write && !m_sweep && !(cfg_zr[c] && int'(dr) == 0);
    endfunction

    function automatic void model_read(input int c, input int a, output int d, output bit v);
        if (cfg_zr[c] && a == 0) begin
            d = 0; v = 1'b1;
        end else if (cfg_byp[c] && accepted(c) && a == int'(dr)) begin
            d = int'(wrData); v = 1'b1;
        end else begin
            d = m_mem[c][a]; v = m_val[c][a];
        end
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < NC; c++) begin
            bit acc;
            acc = accepted(c);
            m_drop[c] = write && !acc;
            if (acc) begin
                m_mem[c][dr] = int'(wrData);
                m_val[c][dr] = 1'b1;
            end
        end
        if (m_sweep) begin
            for (int c = 0; c < NC; c++) begin
                m_mem[c][m_idx] = 0;
                m_val[c][m_idx] = 1'b0;
            end
            m_idx++;
            if (m_idx == D) m_sweep = 1'b0;
        end else if (clear) begin
            m_sweep = 1'b1;
            m_idx   = 0;
        end
    endfunction

    task automatic check_all(input string name);
        for (int c = 0; c < NC; c++) begin
            int d; bit v;
            model_read(c, int'(sr1), d, v);
            check($sformatf("%s c%0d rdData1", name, c), 32'(rd1[c]), 32'(d));
            check($sformatf("%s c%0d rdValid1", name, c), 32'(v1[c]), 32'(v));
            model_read(c, int'(sr2), d, v);
            check($sformatf("%s c%0d rdData2", name, c), 32'(rd2[c]), 32'(d));
            check($sformatf("%s c%0d rdValid2", name, c), 32'(v2[c]), 32'(v));
            check($sformatf("%s c%0d busy", name, c), 32'(busy[c]), 32'(m_sweep));
            check($sformatf("%s c%0d wr_drop", name, c), 32'(drop[c]), 32'(m_drop[c]));
        end
    endtask

    task automatic apply(input string name, input logic w, input int d, input int wd,
                         input int a1, input int a2, input logic clr);
        write  = w;
        dr     = 3'(d);
        wrData = 8'(wd);
        sr1    = 3'(a1);
        sr2    = 3'(a2);
        clear  = clr;
        #2;
        check_all(name);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic       w;
        logic [2:0] d;
        logic [7:0] wd;
        logic [2:0] a1, a2;
        logic [7:0] e1, e2;
        logic       ev1, ev2;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cycles;

        // Fill/read table, expectations for the bypassing bank (config 0).
        for (int k = 0; k < 8; k++) begin
            tbl[k] = '{1'b1, 3'(k), 8'(10 * k), 3'(k), 3'((k + 7) % 8),
                       8'(10 * k), (k == 0) ? 8'd0 : 8'(10 * (k - 1)), 1'b1, k != 0};
        end
        for (int k = 0; k < 7; k++) begin
            tbl[8 + k] = '{1'b0, 3'd0, 8'd0, 3'(k), 3'(k + 1),
                           8'(10 * k), 8'(10 * (k + 1)), 1'b1, 1'b1};
        end

        model_reset();
        #12;
        reset = 1'b0;
        tick();

        // Reset state on every address
        for (int a = 0; a < D; a++) begin
            apply("reset read", 1'b0, 0, 0, a, (a + 1) % D, 1'b0);
            check("reset rd0", 32'(rd1[0]), 32'd0);
            check("reset v0", 32'(v1[0]), 32'd0);
        end
        tick();

        // Table-driven fill and readback
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i].w, int'(tbl[i].d), int'(tbl[i].wd),
                  int'(tbl[i].a1), int'(tbl[i].a2), 1'b0);
            check($sformatf("tbl%0d rd1", i), 32'(rd1[0]), 32'(tbl[i].e1));
            check($sformatf("tbl%0d rd2", i), 32'(rd2[0]), 32'(tbl[i].e2));
            check($sformatf("tbl%0d v1", i), 32'(v1[0]), 32'(tbl[i].ev1));
            check($sformatf("tbl%0d v2", i), 32'(v2[0]), 32'(tbl[i].ev2));
            tick();
        end

        // Bypass versus no bypass
        apply("bypass", 1'b1, 3, 8'hA5, 3, 3, 1'b0);
        check("bypass rd1", 32'(rd1[0]), 32'hA5);
        check("no-bypass old rd1", 32'(rd1[1]), 32'd30);
        tick();
        apply("after write", 1'b0, 0, 0, 3, 3, 1'b0);
        check("no-bypass new rd1", 32'(rd1[1]), 32'hA5);
        tick();

        // Hardwired zero register
        apply("zero write", 1'b1, 0, 8'h55, 0, 0, 1'b0);
        check("zero rd1", 32'(rd1[2]), 32'd0);
        check("zero v1", 32'(v1[2]), 32'd1);
        tick();
        apply("zero after", 1'b0, 0, 0, 0, 1, 1'b0);
        check("zero drop pulse", 32'(drop[2]), 32'd1);
        check("zero rd1 after", 32'(rd1[2]), 32'd0);
        tick();
        apply("zero idle", 1'b0, 0, 0, 0, 1, 1'b0);
        check("zero drop end", 32'(drop[2]), 32'd0);
        tick();

        // Clear sweep with a write attempted during it
        apply("clear req", 1'b0, 0, 0, 5, 0, 1'b1);
        tick();
        busy_cycles = 0;
        for (int i = 0; i < 20 && busy[0]; i++) begin
            busy_cycles++;
            apply($sformatf("sweep%0d", i), i == 2, 5, 8'h77, 5, i % D, 1'b0);
            if (i == 3) check("sweep drop pulse", 32'(drop[0]), 32'd1);
            if (i == 4) check("sweep drop end", 32'(drop[0]), 32'd0);
            tick();
        end
        check("busy cycles", 32'(busy_cycles), 32'd8);
        for (int a = 0; a < D; a++) begin
            apply("post sweep", 1'b0, 0, 0, a, 5, 1'b0);
            check("post sweep r5", 32'(rd2[0]), 32'd0);
            check("post sweep valid", 32'(v1[0]), 32'd0);
        end
        tick();

        // Reset in the middle of a sweep
        for (int a = 0; a < D; a++) begin
            apply("refill", 1'b1, a, 8'hC0 + a, a, 0, 1'b0);
            tick();
        end
        apply("clear2", 1'b0, 0, 0, 0, 0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply("sweep2", 1'b0, 0, 0, 7, 6, 1'b0);
            tick();
        end
        reset = 1'b1;
        model_reset();
        #1;
        check("mid-sweep reset busy", 32'(busy[0]), 32'd0);
        for (int a = 0; a < D; a++) begin
            sr1 = 3'(a);
            sr2 = 3'((a + 3) % D);
            #1;
            check("mid-sweep reset rd", 32'(rd1[0]), 32'd0);
            check_all("in reset");
        end
        @(negedge clk);
        reset = 1'b0;
        apply("post reset write", 1'b1, 2, 8'h3C, 2, 2, 1'b0);
        tick();
        apply("post reset read", 1'b0, 0, 0, 2, 7, 1'b0);
        check("post reset r2", 32'(rd1[0]), 32'h3C);
        check("post reset r2 valid", 32'(v1[0]), 32'd1);
        check("post reset r7", 32'(rd2[0]), 32'd0);
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            apply("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, D - 1)),
                  int'($urandom_range(0, D - 1)), $urandom_range(0, 19) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
